// File: rtl/des_key_schedule_pkg.sv
// Shared DES key-schedule constants: geometry, PC1 table, shift schedule,
// FSM state type and the half-register rotate helper.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;
  localparam int ROUNDS   = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Output bit j+1 of PC1 takes DES key bit PC1_TABLE[j] (1-based, bit 1 = MSB).
  localparam int unsigned PC1_TABLE [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Entry i is the left-rotate amount for DES round i+1.
  localparam logic [15:0][1:0] SHIFT_SCHED = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

  // Direction mux followed by a 1-or-2 position rotate of one 28-bit half.
  function automatic logic [HALF_W-1:0] rot28(
    input logic [HALF_W-1:0] x,
    input logic              right,
    input logic              two
  );
    logic [HALF_W-1:0] r1;
    r1 = right ? {x[0], x[HALF_W-1:1]} : {x[HALF_W-2:0], x[HALF_W-1]};
    return two ? (right ? {r1[0], r1[HALF_W-1:1]} : {r1[HALF_W-2:0], r1[HALF_W-1]}) : r1;
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Request/subkey handshake bundle between the key schedule and its user.
interface des_key_schedule_if;
  import des_pkg::*;

  logic                start;
  logic                decrypt;
  logic [KEY_W-1:0]    key;
  logic                subkey_valid;
  logic                subkey_ready;
  logic [SUBKEY_W-1:0] subkey;
  logic [3:0]          round;
  logic                busy;
  logic                done;

  modport master (
    output start, decrypt, key, subkey_ready,
    input  subkey_valid, subkey, round, busy, done
  );

  modport slave (
    input  start, decrypt, key, subkey_ready,
    output subkey_valid, subkey, round, busy, done
  );

endinterface

// File: rtl/des_key_schedule_pc1.sv
// DES Permuted Choice 1: 64-bit key to 56-bit {C,D}, pure wiring.
module des_pc1
  import des_pkg::*;
(
  input  logic [KEY_W-1:0]    i_key,
  output logic [2*HALF_W-1:0] o_cd
);

  // Parity bits never reach the schedule.
  logic w_unused_parity;
  assign w_unused_parity = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                             i_key[24], i_key[16], i_key[8],  i_key[0]};

  genvar gi;
  generate
    for (gi = 0; gi < 2*HALF_W; gi++) begin : g_pc1
      assign o_cd[2*HALF_W-1-gi] = i_key[KEY_W - PC1_TABLE[gi]];
    end
  endgenerate

endmodule

// File: rtl/des_key_schedule_pc2.sv
// DES Permuted Choice 2: 56-bit {C,D} to 48-bit round subkey, pure wiring.
module des_pc2 (
  input  logic [55:0] i_cd,
  output logic [47:0] o_subkey
);

  localparam int unsigned PC2_TABLE [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // PC2 discards eight of the 56 {C,D} bits.
  logic w_unused_cd;
  assign w_unused_cd = ^i_cd;

  genvar gi;
  generate
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      assign o_subkey[47-gi] = i_cd[56 - PC2_TABLE[gi]];
    end
  endgenerate

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: one 48-bit subkey per valid/ready handshake,
// in K1..K16 or K16..K1 order.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  des_key_schedule_if.slave   io_ks
);

  state_e              r_state;
  logic [HALF_W-1:0]   r_c;
  logic [HALF_W-1:0]   r_d;
  logic [3:0]          r_round;
  logic                r_decrypt;
  logic                r_done;

  logic [2*HALF_W-1:0] w_pc1;
  logic [HALF_W-1:0]   w_pc1_c;
  logic [HALF_W-1:0]   w_pc1_d;
  logic [HALF_W-1:0]   w_load_c;
  logic [HALF_W-1:0]   w_load_d;
  logic [HALF_W-1:0]   w_step_c;
  logic [HALF_W-1:0]   w_step_d;
  logic [1:0]          w_step_amt;
  logic                w_step_two;
  logic                w_load;
  logic                w_fire;
  logic                w_last;
  logic [SUBKEY_W-1:0] w_subkey;

  des_pc1 u_pc1 (
    .i_key (io_ks.key),
    .o_cd  (w_pc1)
  );

  assign w_pc1_c = w_pc1[2*HALF_W-1:HALF_W];
  assign w_pc1_d = w_pc1[HALF_W-1:0];

  // Decrypt starts from the unrotated halves: 28 cumulative shifts give K16.
  assign w_load_c = io_ks.decrypt ? w_pc1_c : rot28(w_pc1_c, 1'b0, 1'b0);
  assign w_load_d = io_ks.decrypt ? w_pc1_d : rot28(w_pc1_d, 1'b0, 1'b0);

  assign w_load = (r_state == IDLE) && io_ks.start;
  assign w_fire = (r_state == RUN) && io_ks.subkey_ready;
  assign w_last = (r_round == 4'd15);

  // Decrypt walks the schedule backwards, undoing the shift of the round just left.
  assign w_step_amt = r_decrypt ? SHIFT_SCHED[4'd15 - r_round]
                                : SHIFT_SCHED[r_round + 4'd1];
  assign w_step_two = (w_step_amt == 2'd2);
  assign w_step_c   = rot28(r_c, r_decrypt, w_step_two);
  assign w_step_d   = rot28(r_d, r_decrypt, w_step_two);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_c       <= '0;
      r_d       <= '0;
      r_round   <= 4'd0;
      r_decrypt <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_c       <= w_load_c;
        r_d       <= w_load_d;
        r_decrypt <= io_ks.decrypt;
        r_round   <= 4'd0;
        r_state   <= RUN;
      end else if (w_fire) begin
        if (w_last) begin
          r_state <= IDLE;
          r_round <= 4'd0;
          r_done  <= 1'b1;
        end else begin
          r_round <= r_round + 4'd1;
          r_c     <= w_step_c;
          r_d     <= w_step_d;
        end
      end
    end
  end

  des_pc2 u_pc2 (
    .i_cd     ({r_c, r_d}),
    .o_subkey (w_subkey)
  );

  assign io_ks.subkey       = w_subkey;
  assign io_ks.subkey_valid = (r_state == RUN);
  assign io_ks.busy         = (r_state == RUN);
  assign io_ks.round        = r_round;
  assign io_ks.done         = r_done;

endmodule
